// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: owner encoding and LSU bmask codes shared by the bus arbiter (optional grant statistics: ARB_STATS_EN)
package lsu_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_e;
  localparam logic [2:0] BM_BYTE  = 3'b000;
  localparam logic [2:0] BM_HALF  = 3'b001;
  localparam logic [2:0] BM_WORD  = 3'b010;
  localparam logic [2:0] BM_BYTEU = 3'b100;
  localparam logic [2:0] BM_HALFU = 3'b101;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker, one-hot grant favouring the master not granted last
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  // on contention hand the bus to the master that did not win last time
  always_comb gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter: round-robin two-master LSU port arbiter with locked bursts and starvation cap (ARB_STATS_EN adds grant counters)
module lsu_bus_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_req,
  input  logic              i_m1_req,
  input  logic              i_m0_lock,
  input  logic              i_m1_lock,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m0_wren,
  input  logic              i_m1_wren,
  input  logic [2:0]        i_m0_bmask,
  input  logic [2:0]        i_m1_bmask,
  output logic              o_m0_gnt,
  output logic              o_m1_gnt,
  output logic              o_m0_rvalid,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_s_req,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic              o_s_wren,
  output logic [2:0]        o_s_bmask,
  input  logic [DATA_W-1:0] i_s_rdata,
  output logic [1:0]        o_owner
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       o_m0_gnt_cnt,
  output logic [15:0]       o_m1_gnt_cnt,
  output logic [15:0]       o_starve_cnt
`endif
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  owner_e state, state_nx;
  logic last, tag_v, tag_id, own0, own1, forced, gid, contested, kept;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0] req, lock, rr_gnt, gnt;
  assign req  = {i_m1_req, i_m0_req};
  assign lock = {i_m1_lock, i_m0_lock};
  rr_pick2 u_pick (.req(req), .last(last), .gnt(rr_gnt));
  // owner priority with forced hand-over at the cap, otherwise round-robin; next owner and contested-run length
  always_comb begin
    own0      = state == OWN0 && req[0];
    own1      = state == OWN1 && req[1];
    forced    = ((own0 && req[1]) || (own1 && req[0])) && cnt == CNT_MAX;
    gnt       = !i_reset ? 2'b00 : own0 ? (forced ? 2'b10 : 2'b01) : own1 ? (forced ? 2'b01 : 2'b10) : rr_gnt;
    gid       = gnt[1];
    contested = gid ? req[0] : req[1];
    kept      = gid ? state == OWN1 : state == OWN0;
    state_nx  = (|gnt && lock[gid]) ? (gid ? OWN1 : OWN0) : IDLE;
    cnt_nx    = (|gnt && lock[gid] && contested && !forced) ? (kept ? cnt + CNT_W'(1) : CNT_W'(1)) : '0;
  end
  // ownership, round-robin pointer, lock run and the one-deep load response tag
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      tag_v  <= 1'b0;
      tag_id <= 1'b0;
    end else begin
      state  <= state_nx;
      last   <= |gnt ? gid : last;
      cnt    <= cnt_nx;
      tag_v  <= |gnt && !o_s_wren;
      tag_id <= gid;
    end
  end
  assign o_m0_gnt    = gnt[0];
  assign o_m1_gnt    = gnt[1];
  assign o_s_req     = |gnt;
  assign o_s_addr    = gnt[0] ? i_m0_addr  : gnt[1] ? i_m1_addr  : '0;
  assign o_s_wdata   = gnt[0] ? i_m0_wdata : gnt[1] ? i_m1_wdata : '0;
  assign o_s_wren    = gnt[0] ? i_m0_wren  : gnt[1] && i_m1_wren;
  assign o_s_bmask   = gnt[0] ? i_m0_bmask : gnt[1] ? i_m1_bmask : 3'b000;
  assign o_m0_rvalid = tag_v && !tag_id;
  assign o_m1_rvalid = tag_v && tag_id;
  assign o_m0_rdata  = o_m0_rvalid ? i_s_rdata : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_s_rdata : '0;
  assign o_owner     = state;
`ifdef ARB_STATS_EN
  // saturating grant and forced-switch counters
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_m0_gnt_cnt <= '0;
      o_m1_gnt_cnt <= '0;
      o_starve_cnt <= '0;
    end else begin
      o_m0_gnt_cnt <= (gnt[0] && ~&o_m0_gnt_cnt) ? o_m0_gnt_cnt + 16'd1 : o_m0_gnt_cnt;
      o_m1_gnt_cnt <= (gnt[1] && ~&o_m1_gnt_cnt) ? o_m1_gnt_cnt + 16'd1 : o_m1_gnt_cnt;
      o_starve_cnt <= (forced && ~&o_starve_cnt) ? o_starve_cnt + 16'd1 : o_starve_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// tb_lsu_bus_arbiter: scoreboard bench, reference arbitration model feeds expected grants/responses to a monitor
module tb_lsu_bus_arbiter;
  import lsu_arb_pkg::*;
  localparam int LM = 8;
  logic i_clk = 1'b0, i_reset = 1'b0;
  logic i_m0_req, i_m1_req, i_m0_lock, i_m1_lock, i_m0_wren, i_m1_wren;
  logic [31:0] i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata, i_s_rdata;
  logic [2:0] i_m0_bmask, i_m1_bmask;
  logic o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_s_req, o_s_wren;
  logic [31:0] o_m0_rdata, o_m1_rdata, o_s_addr, o_s_wdata;
  logic [2:0] o_s_bmask;
  logic [1:0] o_owner;
`ifdef ARB_STATS_EN
  logic [15:0] o_m0_gnt_cnt, o_m1_gnt_cnt, o_starve_cnt;
`endif

  always #5 i_clk = ~i_clk;

  lsu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LM)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_req(i_m0_req), .i_m1_req(i_m1_req), .i_m0_lock(i_m0_lock), .i_m1_lock(i_m1_lock),
    .i_m0_addr(i_m0_addr), .i_m1_addr(i_m1_addr), .i_m0_wdata(i_m0_wdata), .i_m1_wdata(i_m1_wdata),
    .i_m0_wren(i_m0_wren), .i_m1_wren(i_m1_wren), .i_m0_bmask(i_m0_bmask), .i_m1_bmask(i_m1_bmask),
    .o_m0_gnt(o_m0_gnt), .o_m1_gnt(o_m1_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m1_rvalid(o_m1_rvalid),
    .o_m0_rdata(o_m0_rdata), .o_m1_rdata(o_m1_rdata), .o_s_req(o_s_req), .o_s_addr(o_s_addr),
    .o_s_wdata(o_s_wdata), .o_s_wren(o_s_wren), .o_s_bmask(o_s_bmask), .i_s_rdata(i_s_rdata),
    .o_owner(o_owner)
`ifdef ARB_STATS_EN
    , .o_m0_gnt_cnt(o_m0_gnt_cnt), .o_m1_gnt_cnt(o_m1_gnt_cnt), .o_starve_cnt(o_starve_cnt)
`endif
  );

  typedef struct {int cyc; int id; logic [31:0] addr; logic [31:0] wdata; logic wren; logic [2:0] bm;} xact_t;
  typedef struct {int cyc; int id; logic [31:0] data;} rsp_t;
  xact_t exp_q[$];
  rsp_t  rsp_q[$];
  int hist[$];
  int total = 0, bad = 0, cyc = 0;
  logic rst_want = 1'b0;
  logic [1:0] exp_owner = 2'd0;
  logic p_req[2], p_lock[2], p_wren[2];
  logic [31:0] p_addr[2], p_wdata[2];
  logic [2:0] p_bm[2];
  logic [2:0] bms[5];
  // reference: who holds the bus, who won last, how many contested locked grants in a row, stats
  int m_owner = 0, m_last = 1, m_run = 0, m_g0 = 0, m_g1 = 0, m_st = 0;

  function automatic logic [31:0] sdat(int c);
    return 32'hC0DE0000 ^ (32'(c) * 32'h9E3779B9);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic arm(int m, logic [31:0] a, logic [31:0] d, logic w, logic [2:0] b, logic l);
    p_req[m] = 1'b1; p_addr[m] = a; p_wdata[m] = d; p_wren[m] = w; p_bm[m] = b; p_lock[m] = l;
  endtask

  task automatic drive();
    i_m0_req = p_req[0]; i_m0_lock = p_lock[0]; i_m0_addr = p_addr[0];
    i_m0_wdata = p_wdata[0]; i_m0_wren = p_wren[0]; i_m0_bmask = p_bm[0];
    i_m1_req = p_req[1]; i_m1_lock = p_lock[1]; i_m1_addr = p_addr[1];
    i_m1_wdata = p_wdata[1]; i_m1_wren = p_wren[1]; i_m1_bmask = p_bm[1];
  endtask

  // decide this cycle's winner from the arbitration rules and queue what the DUT must show
  task automatic model_step();
    int g, n;
    bit forced;
    g = -1; forced = 0;
    exp_owner = 2'(m_owner);
    if (m_owner != 0 && p_req[m_owner-1]) begin
      n = m_owner - 1;
      if (m_run == LM && p_req[1-n]) begin g = 1 - n; forced = 1; end
      else g = n;
    end else if (p_req[0] && p_req[1]) g = 1 - m_last;
    else if (p_req[0]) g = 0;
    else if (p_req[1]) g = 1;
    if (g < 0) begin
      m_owner = 0; m_run = 0;
    end else begin
      exp_q.push_back('{cyc, g, p_addr[g], p_wdata[g], p_wren[g], p_bm[g]});
      if (!p_wren[g]) rsp_q.push_back('{cyc + 1, g, sdat(cyc + 1)});
      m_run = (p_lock[g] && p_req[1-g] && !forced) ? ((m_owner == g + 1) ? m_run + 1 : 1) : 0;
      m_owner = p_lock[g] ? g + 1 : 0;
      m_last = g;
      if (g == 0) m_g0++; else m_g1++;
      if (forced) m_st++;
      p_req[g] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge i_clk); #1;
    cyc++;
    i_reset = rst_want;
    i_s_rdata = sdat(cyc);
    drive();
    if (!rst_want) begin
      exp_q.delete(); rsp_q.delete();
      m_owner = 0; m_last = 1; m_run = 0; m_g0 = 0; m_g1 = 0; m_st = 0; exp_owner = 2'd0;
    end else model_step();
  endtask

  // monitor: compare whatever the DUT presents against the queued expectations
  initial forever begin
    xact_t x;
    rsp_t r;
    logic rv;
    logic [31:0] rd;
    @(negedge i_clk);
    if (!i_reset) begin
      chk("rst_sreq", 64'(o_s_req), 0);
      chk("rst_gnt", 64'({o_m1_gnt, o_m0_gnt}), 0);
      chk("rst_rvalid", 64'({o_m1_rvalid, o_m0_rvalid}), 0);
      chk("rst_rdata", 64'(o_m0_rdata | o_m1_rdata), 0);
      chk("rst_owner", 64'(o_owner), 0);
    end else begin
      chk("one_gnt", 64'(o_m0_gnt & o_m1_gnt), 0);
      chk("owner", 64'(o_owner), 64'(exp_owner));
      if (o_s_req) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_gnt cyc=%0d: got gnt=%b want none", cyc, {o_m1_gnt, o_m0_gnt});
        end else begin
          x = exp_q.pop_front();
          chk("gnt_cyc", 64'(cyc), 64'(x.cyc));
          chk("gnt_id", 64'({o_m1_gnt, o_m0_gnt}), (x.id == 1) ? 64'd2 : 64'd1);
          chk("s_addr", 64'(o_s_addr), 64'(x.addr));
          chk("s_wdata", 64'(o_s_wdata), 64'(x.wdata));
          chk("s_wren", 64'(o_s_wren), 64'(x.wren));
          chk("s_bmask", 64'(o_s_bmask), 64'(x.bm));
          hist.push_back(int'(o_m1_gnt));
        end
      end
      for (int m = 0; m < 2; m++) begin
        rv = m == 1 ? o_m1_rvalid : o_m0_rvalid;
        rd = m == 1 ? o_m1_rdata : o_m0_rdata;
        if (rv) begin
          if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rvalid cyc=%0d: got rvalid on m%0d want none", cyc, m);
          end else begin
            r = rsp_q.pop_front();
            chk("rv_cyc", 64'(cyc), 64'(r.cyc));
            chk("rv_id", 64'(m), 64'(r.id));
            chk("rv_data", 64'(rd), 64'(r.data));
          end
        end else chk("rdata_idle", 64'(rd), 0);
      end
    end
  end

  initial begin
    int k, lead;
    bms = '{BM_BYTE, BM_HALF, BM_WORD, BM_BYTEU, BM_HALFU};
    for (int m = 0; m < 2; m++) begin
      p_req[m] = 1'b0; p_lock[m] = 1'b0; p_wren[m] = 1'b0; p_addr[m] = '0; p_wdata[m] = '0; p_bm[m] = '0;
    end
    i_s_rdata = '0;
    drive();
    // both masters load-request while in reset (must stay ungranted), then from cycle 1 after release
    arm(0, 32'h100, 32'h0, 1'b0, BM_WORD, 1'b0);
    arm(1, 32'h200, 32'h0, 1'b0, BM_WORD, 1'b0);
    repeat (3) step();
    rst_want = 1'b1;
    repeat (4) step();
    // master 0 store to the LED register
    arm(0, 32'h7020, 32'h0000_03FF, 1'b1, 3'b010, 1'b0);
    for (int s = 0; s < 10 && p_req[0]; s++) step();
    chk("store_served", 64'(p_req[0]), 0);
    repeat (2) step();
    // both masters keep single unlocked loads pending: grants must alternate
    hist.delete();
    for (int s = 0; s < 10; s++) begin
      for (int m = 0; m < 2; m++) if (!p_req[m]) arm(m, 32'h400 + 32'(s * 4), 32'h0, 1'b0, BM_WORD, 1'b0);
      step();
    end
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    step();
    for (int i = 1; i < 10; i++) chk("alternate", 64'(hist.size() > i ? hist[i] : 9), 64'(hist.size() > i ? 1 - hist[i-1] : 0));
    // make master 0 the last winner so master 1 opens the contested burst
    repeat (2) step();
    arm(0, 32'h500, 32'h0, 1'b0, BM_WORD, 1'b0);
    step();
    step();
    hist.delete();
    k = 0;
    for (int s = 0; s < 200 && (k < 20 || p_req[1]); s++) begin
      if (!p_req[1] && k < 20) begin
        arm(1, 32'h7000 + 32'(k * 4), $urandom, 1'b1, BM_WORD, k < 19);
        k++;
      end
      if (!p_req[0]) arm(0, 32'h600, 32'h0, 1'b0, BM_WORD, 1'b0);
      step();
    end
    chk("burst_done", 64'({k == 20, p_req[1]}), 64'b10);
    p_req[0] = 1'b0;
    step();
    lead = 0;
    while (lead < hist.size() && hist[lead] == 1) lead++;
    chk("burst_run", 64'(lead), 64'(LM));
    chk("burst_switch", 64'(hist.size() > lead ? hist[lead] : 9), 0);
    chk("burst_resume", 64'(hist.size() > lead + 1 ? hist[lead+1] : 9), 1);
    // reset while master 1 owns the bus with a load outstanding
    repeat (2) step();
    for (int s = 0; s < 3; s++) begin
      arm(1, 32'h800 + 32'(s * 4), 32'h0, 1'b0, BM_WORD, 1'b1);
      step();
    end
    arm(0, 32'h900, 32'h0, 1'b0, BM_WORD, 1'b0);
    arm(1, 32'h904, 32'h0, 1'b0, BM_WORD, 1'b1);
    rst_want = 1'b0;
    repeat (2) step();
    rst_want = 1'b1;
    hist.delete();
    repeat (2) step();
    chk("post_rst_first", 64'(hist.size() > 0 ? hist[0] : 9), 0);
    // random traffic
    for (int s = 0; s < 600; s++) begin
      for (int m = 0; m < 2; m++)
        if (!p_req[m] && $urandom_range(1) == 1)
          arm(m, $urandom, $urandom, 1'($urandom_range(1)), bms[$urandom_range(4)],
              m == 1 ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0));
      step();
    end
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    repeat (3) step();
    chk("exp_q_empty", 64'(exp_q.size()), 0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 0);
`ifdef ARB_STATS_EN
    chk("m0_gnt_cnt", 64'(o_m0_gnt_cnt), 64'(m_g0));
    chk("m1_gnt_cnt", 64'(o_m1_gnt_cnt), 64'(m_g1));
    chk("starve_cnt", 64'(o_starve_cnt), 64'(m_st));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
